// File: rtl/riscv_types.sv
// RV32A atomic function codes shared by the load/store unit.
// amo_t is a plain 5-bit vector so that unlisted encodings flow through
// the datapath without enum casting problems.
package riscv_types;

   typedef logic [4:0] amo_t;

   localparam amo_t AMO_ADD_FN5  = 5'b00000;
   localparam amo_t AMO_SWAP_FN5 = 5'b00001;
   localparam amo_t AMO_LR_FN5   = 5'b00010;
   localparam amo_t AMO_SC_FN5   = 5'b00011;
   localparam amo_t AMO_XOR_FN5  = 5'b00100;
   localparam amo_t AMO_OR_FN5   = 5'b01000;
   localparam amo_t AMO_AND_FN5  = 5'b01100;
   localparam amo_t AMO_MIN_FN5  = 5'b10000;
   localparam amo_t AMO_MAX_FN5  = 5'b10100;
   localparam amo_t AMO_MINU_FN5 = 5'b11000;
   localparam amo_t AMO_MAXU_FN5 = 5'b11100;

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO datapath: rs1 is the loaded memory word, rs2 the
// register operand, rd the value to be written back to memory.
// Encodings without an arithmetic meaning (LR, SC, unused codes) give zero.
module amo_alu
   import riscv_types::*;
#(
   parameter int WIDTH = 32
) (
   input  amo_t             amo_type,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   output logic [WIDTH-1:0] rd
);

   logic signed_lt;
   logic unsigned_lt;

   assign signed_lt   = $signed(rs1) < $signed(rs2);
   assign unsigned_lt = rs1 < rs2;

   // Select the read-modify-write result for the requested function
   always_comb begin
      rd = '0;
      case (amo_type)
         AMO_ADD_FN5:  rd = rs1 + rs2;
         AMO_SWAP_FN5: rd = rs2;
         AMO_XOR_FN5:  rd = rs1 ^ rs2;
         AMO_OR_FN5:   rd = rs1 | rs2;
         AMO_AND_FN5:  rd = rs1 & rs2;
         AMO_MIN_FN5:  rd = signed_lt   ? rs1 : rs2;
         AMO_MAX_FN5:  rd = signed_lt   ? rs2 : rs1;
         AMO_MINU_FN5: rd = unsigned_lt ? rs1 : rs2;
         AMO_MAXU_FN5: rd = unsigned_lt ? rs2 : rs1;
         default:      rd = '0;
      endcase
   end

endmodule

// File: rtl/amo_sequencer.sv
// Read-modify-write sequencer for RV32A atomics. One request in flight:
// load the word, run it through amo_alu, store the result, return the
// old word. LR/SC reservation tracking is built only when the macro
// AMO_SEQ_LRSC_EN is defined; otherwise LR is a plain load and SC always
// fails without touching memory.
module amo_sequencer
   import riscv_types::*;
#(
   parameter int WIDTH = 32,
   parameter int ID_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [4:0]       req_op,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_data,
   input  logic [ID_W-1:0]  req_id,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_rvalid,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [ID_W-1:0]  res_id,
   input  logic             resv_clear
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_REQ,
      LOAD_WAIT,
      ALU,
      STORE_REQ,
      RESP
   } amo_seq_state_t;

   localparam logic [WIDTH-1:0] WORD_MASK  = {{(WIDTH-2){1'b1}}, 2'b00};
   localparam logic [WIDTH-1:0] SC_FAIL_RD = WIDTH'(1);

   amo_seq_state_t   state;
   amo_t             op_r;
   logic [WIDTH-1:0] old_r;
   logic [WIDTH-1:0] data_r;
   logic [ID_W-1:0]  id_r;
   logic [WIDTH-1:0] alu_rd;
   logic [WIDTH-1:0] req_word;
   logic             accept;

   assign req_word = req_addr & WORD_MASK;
   assign accept   = req_valid && req_ready && (state == IDLE);

   amo_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .amo_type (op_r),
      .rs1      (old_r),
      .rs2      (data_r),
      .rd       (alu_rd)
   );

`ifdef AMO_SEQ_LRSC_EN
   logic             resv_valid;
   logic [WIDTH-1:0] resv_addr;
   logic             sc_hit;

   // A snoop in the same cycle as the SC wins, so the SC sees no reservation
   assign sc_hit = resv_valid && !resv_clear && (resv_addr == req_word);

   // Reservation register: set by LR, dropped by SC, snoops and AMO stores to the word
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resv_valid <= 1'b0;
         resv_addr  <= '0;
      end else begin
         if (accept && (req_op == AMO_LR_FN5)) begin
            resv_valid <= 1'b1;
            resv_addr  <= req_word;
         end
         if (accept && (req_op == AMO_SC_FN5)) begin
            resv_valid <= 1'b0;
         end
         if ((state == STORE_REQ) && mem_ready && (op_r != AMO_SC_FN5) &&
             (mem_addr == resv_addr)) begin
            resv_valid <= 1'b0;
         end
         if (resv_clear) begin
            resv_valid <= 1'b0;
         end
      end
   end
`else
   logic unused_resv_clear;
   assign unused_resv_clear = resv_clear;
`endif

   // Main sequencer: all handshake outputs are registered and only change on transitions
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b0;
         mem_valid <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
         op_r      <= '0;
         old_r     <= '0;
         data_r    <= '0;
         id_r      <= '0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  req_ready <= 1'b0;
                  op_r      <= req_op;
                  data_r    <= req_data;
                  id_r      <= req_id;
                  mem_addr  <= req_word;
                  if (req_op == AMO_SC_FN5) begin
`ifdef AMO_SEQ_LRSC_EN
                     if (sc_hit) begin
                        mem_valid <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= req_data;
                        state     <= STORE_REQ;
                     end else begin
                        res_valid <= 1'b1;
                        res_data  <= SC_FAIL_RD;
                        res_id    <= req_id;
                        state     <= RESP;
                     end
`else
                     res_valid <= 1'b1;
                     res_data  <= SC_FAIL_RD;
                     res_id    <= req_id;
                     state     <= RESP;
`endif
                  end else begin
                     mem_valid <= 1'b1;
                     mem_we    <= 1'b0;
                     state     <= LOAD_REQ;
                  end
               end
            end
            LOAD_REQ: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  state     <= LOAD_WAIT;
               end
            end
            LOAD_WAIT: begin
               if (mem_rvalid) begin
                  old_r <= mem_rdata;
                  if (op_r == AMO_LR_FN5) begin
                     res_valid <= 1'b1;
                     res_data  <= mem_rdata;
                     res_id    <= id_r;
                     state     <= RESP;
                  end else begin
                     state <= ALU;
                  end
               end
            end
            ALU: begin
               mem_wdata <= alu_rd;
               mem_valid <= 1'b1;
               mem_we    <= 1'b1;
               state     <= STORE_REQ;
            end
            STORE_REQ: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  mem_we    <= 1'b0;
                  res_valid <= 1'b1;
                  res_id    <= id_r;
                  res_data  <= (op_r == AMO_SC_FN5) ? '0 : old_r;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
